// File: rtl/sata_transport_command_dev.sv
// Device-side SATA transport command engine: H2D Register FIS in, D2H Register FIS out.
// Optional macro SATA_DEV_FIS_CHECK_EN enables DW0 type/C-bit checking on received frames.
`timescale 1ns/1ps

package sata_dev_pkg;
  typedef struct packed {
    logic [7:0]  command;
    logic [7:0]  features;
    logic [47:0] lba;
    logic [15:0] count;
    logic [7:0]  device;
    logic [7:0]  control;
  } h2d_t;

  typedef struct packed {
    logic [7:0]  status;
    logic [7:0]  error;
    logic [47:0] lba;
    logic [15:0] count;
    logic [7:0]  device;
  } d2h_t;

  typedef struct packed {
    h2d_t h2d;
    d2h_t d2h;
  } cmd_t;
endpackage

module sata_transport_command_dev
  import sata_dev_pkg::*;
#(
  parameter int USER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s_axis_link_tdata,
  input  logic [USER_W-1:0] s_axis_link_tuser,
  input  logic              s_axis_link_tvalid,
  output logic              s_axis_link_tready,
  output logic [31:0]       m_axis_link_tdata,
  output logic [USER_W-1:0] m_axis_link_tuser,
  output logic              m_axis_link_tvalid,
  input  logic              m_axis_link_tready,
  output cmd_t              h2d_cmd,
  output logic              h2d_req,
  input  logic              h2d_ack,
  input  cmd_t              d2h_cmd,
  input  logic              d2h_req,
  output logic              d2h_ack,
  output logic              rx_err
);

  typedef enum logic [1:0] {R_IDLE, R_RECV, R_HOLD, R_DROP} rx_state_t;
  typedef enum logic       {T_IDLE, T_SEND} tx_state_t;

  // ---------------------------------------------------------------- RX
  rx_state_t   rx_state_reg, rx_state_next;
  logic [2:0]  rcnt_reg, rcnt_next;
  h2d_t        h2d_reg, h2d_next;
  logic        h2d_req_reg, h2d_req_next;
  logic        rx_ready_reg, rx_ready_next;
  logic        rx_err_reg, rx_err_next;

  logic rx_beat, rx_sop, rx_eop, rx_bad, fis_bad;

  assign rx_beat = s_axis_link_tvalid && rx_ready_reg;
  assign rx_eop  = s_axis_link_tuser[0];
  assign rx_sop  = s_axis_link_tuser[1];
  assign rx_bad  = s_axis_link_tuser[6] || s_axis_link_tuser[7];

`ifdef SATA_DEV_FIS_CHECK_EN
  assign fis_bad = (s_axis_link_tdata[31:24] != 8'h27) || !s_axis_link_tdata[23];
`else
  assign fis_bad = 1'b0;
`endif

  always_comb begin
    rx_state_next = rx_state_reg;
    rcnt_next     = rcnt_reg;
    h2d_next      = h2d_reg;
    h2d_req_next  = h2d_req_reg;
    rx_ready_next = rx_ready_reg;
    rx_err_next   = 1'b0;
    case (rx_state_reg)
      R_IDLE, R_RECV: begin
        if (rx_beat) begin
          if (rx_sop) begin
            // A sop mid-frame kills the frame in flight and is treated as a fresh DW0.
            if (rx_state_reg == R_RECV) rx_err_next = 1'b1;
            if (rx_bad || fis_bad || rx_eop) begin
              rx_err_next   = rx_err_next | rx_eop;
              rx_state_next = rx_eop ? R_IDLE : R_DROP;
            end else begin
              h2d_next          = '0;
              h2d_next.command  = s_axis_link_tdata[15:8];
              h2d_next.features = s_axis_link_tdata[7:0];
              rcnt_next         = 3'd1;
              rx_state_next     = R_RECV;
            end
          end else if (rx_state_reg == R_IDLE || rx_bad) begin
            rx_err_next   = rx_eop;
            rx_state_next = rx_eop ? R_IDLE : R_DROP;
          end else if (rcnt_reg == 3'd4) begin
            if (rx_eop) begin
              h2d_req_next  = 1'b1;
              rx_ready_next = 1'b0;
              rx_state_next = R_HOLD;
            end else begin
              rx_state_next = R_DROP;
            end
          end else if (rx_eop) begin
            rx_err_next   = 1'b1;
            rx_state_next = R_IDLE;
          end else begin
            case (rcnt_reg)
              3'd1: begin
                h2d_next.lba[7:0]   = s_axis_link_tdata[31:24];
                h2d_next.lba[15:8]  = s_axis_link_tdata[23:16];
                h2d_next.lba[23:16] = s_axis_link_tdata[15:8];
                h2d_next.device     = s_axis_link_tdata[7:0];
              end
              3'd2: begin
                h2d_next.lba[31:24] = s_axis_link_tdata[31:24];
                h2d_next.lba[39:32] = s_axis_link_tdata[23:16];
                h2d_next.lba[47:40] = s_axis_link_tdata[15:8];
              end
              3'd3: begin
                h2d_next.count[7:0]  = s_axis_link_tdata[31:24];
                h2d_next.count[15:8] = s_axis_link_tdata[23:16];
                h2d_next.control     = s_axis_link_tdata[7:0];
              end
              default: ;
            endcase
            rcnt_next = rcnt_reg + 3'd1;
          end
        end
      end
      R_DROP: begin
        if (rx_beat && rx_eop) begin
          rx_err_next   = 1'b1;
          rx_state_next = R_IDLE;
        end
      end
      R_HOLD: begin
        if (h2d_ack) begin
          h2d_req_next  = 1'b0;
          rx_ready_next = 1'b1;
          rx_state_next = R_IDLE;
        end
      end
      default: rx_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg <= R_IDLE;
      rcnt_reg     <= 3'd0;
      h2d_reg      <= '0;
      h2d_req_reg  <= 1'b0;
      rx_ready_reg <= 1'b1;
      rx_err_reg   <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rcnt_reg     <= rcnt_next;
      h2d_reg      <= h2d_next;
      h2d_req_reg  <= h2d_req_next;
      rx_ready_reg <= rx_ready_next;
      rx_err_reg   <= rx_err_next;
    end
  end

  assign s_axis_link_tready = rx_ready_reg;
  assign h2d_req            = h2d_req_reg;
  assign rx_err             = rx_err_reg;
  assign h2d_cmd            = {h2d_reg, {$bits(d2h_t){1'b0}}};

  // ---------------------------------------------------------------- TX
  tx_state_t         tx_state_reg, tx_state_next;
  logic [2:0]        tcnt_reg, tcnt_next;
  d2h_t              d2h_reg, d2h_next;
  logic              m_valid_reg, m_valid_next;
  logic [31:0]       m_data_reg, m_data_next;
  logic [USER_W-1:0] m_user_reg, m_user_next;
  logic              tx_beat;

  function automatic logic [31:0] d2h_word(input d2h_t c, input logic [2:0] idx);
    case (idx)
      3'd0:    return {8'h34, 8'h40, c.status, c.error};
      3'd1:    return {c.lba[7:0], c.lba[15:8], c.lba[23:16], c.device};
      3'd2:    return {c.lba[31:24], c.lba[39:32], c.lba[47:40], 8'h00};
      3'd3:    return {c.count[7:0], c.count[15:8], 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [USER_W-1:0] d2h_user(input logic [2:0] idx);
    logic [7:0] u;
    u = {2'b00, 4'hF, idx == 3'd0, idx == 3'd4};
    return USER_W'(u);
  endfunction

  assign tx_beat = m_valid_reg && m_axis_link_tready;

  always_comb begin
    tx_state_next = tx_state_reg;
    tcnt_next     = tcnt_reg;
    d2h_next      = d2h_reg;
    m_valid_next  = m_valid_reg;
    m_data_next   = m_data_reg;
    m_user_next   = m_user_reg;
    case (tx_state_reg)
      T_IDLE: begin
        if (d2h_req) begin
          d2h_next      = d2h_cmd.d2h;
          tcnt_next     = 3'd0;
          m_valid_next  = 1'b1;
          m_data_next   = d2h_word(d2h_cmd.d2h, 3'd0);
          m_user_next   = d2h_user(3'd0);
          tx_state_next = T_SEND;
        end
      end
      T_SEND: begin
        // Next beat loads on the handshake edge so the stream has no bubbles.
        if (tx_beat) begin
          if (tcnt_reg == 3'd4) begin
            m_valid_next  = 1'b0;
            m_data_next   = '0;
            m_user_next   = '0;
            tx_state_next = T_IDLE;
          end else begin
            tcnt_next   = tcnt_reg + 3'd1;
            m_data_next = d2h_word(d2h_reg, tcnt_reg + 3'd1);
            m_user_next = d2h_user(tcnt_reg + 3'd1);
          end
        end
      end
      default: tx_state_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= T_IDLE;
      tcnt_reg     <= 3'd0;
      d2h_reg      <= '0;
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
      m_user_reg   <= '0;
    end else begin
      tx_state_reg <= tx_state_next;
      tcnt_reg     <= tcnt_next;
      d2h_reg      <= d2h_next;
      m_valid_reg  <= m_valid_next;
      m_data_reg   <= m_data_next;
      m_user_reg   <= m_user_next;
    end
  end

  assign m_axis_link_tvalid = m_valid_reg;
  assign m_axis_link_tdata  = m_data_reg;
  assign m_axis_link_tuser  = m_user_reg;
  assign d2h_ack            = (tx_state_reg == T_SEND) && tx_beat && (tcnt_reg == 3'd4);

  // Fields that the transport layer does not interpret.
  logic unused_bits;
  assign unused_bits = ^{s_axis_link_tuser, s_axis_link_tdata, d2h_cmd.h2d};

endmodule

// File: tb/tb_sata_transport_command_dev.sv
// Directed bench for sata_transport_command_dev: H2D parse, D2H emit, frame errors, reset abort.
`timescale 1ns/1ps

module tb_sata_transport_command_dev;
  import sata_dev_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [7:0]  s_tuser = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [7:0]  m_tuser;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  cmd_t        h2d_cmd;
  logic        h2d_req;
  logic        h2d_ack = 1'b0;
  cmd_t        d2h_cmd = '0;
  logic        d2h_req = 1'b0;
  logic        d2h_ack;
  logic        rx_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sata_transport_command_dev #(.USER_W(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_axis_link_tdata  (s_tdata),
    .s_axis_link_tuser  (s_tuser),
    .s_axis_link_tvalid (s_tvalid),
    .s_axis_link_tready (s_tready),
    .m_axis_link_tdata  (m_tdata),
    .m_axis_link_tuser  (m_tuser),
    .m_axis_link_tvalid (m_tvalid),
    .m_axis_link_tready (m_tready),
    .h2d_cmd            (h2d_cmd),
    .h2d_req            (h2d_req),
    .h2d_ack            (h2d_ack),
    .d2h_cmd            (d2h_cmd),
    .d2h_req            (d2h_req),
    .d2h_ack            (d2h_ack),
    .rx_err             (rx_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [7:0] u);
    @(negedge clk);
    chk("rx_tready_open", s_tready, 1);
    chk("rx_err_quiet", rx_err, 0);
    chk("h2d_req_low", h2d_req, 0);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tuser  = u;
  endtask

  task automatic end_rx();
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = '0;
  endtask

  task automatic send_h2d(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
    send_beat(w0, 8'h3E);
    send_beat(w1, 8'h3C);
    send_beat(w2, 8'h3C);
    send_beat(w3, 8'h3C);
    send_beat(32'h0, 8'h3D);
    end_rx();
  endtask

  task automatic chk_h2d(input string tag, input logic [7:0] cmd, input logic [7:0] feat,
                         input logic [47:0] lba, input logic [15:0] cnt,
                         input logic [7:0] dev, input logic [7:0] ctrl);
    chk({tag, "_req"}, h2d_req, 1);
    chk({tag, "_rx_err"}, rx_err, 0);
    chk({tag, "_tready_hold"}, s_tready, 0);
    chk({tag, "_command"}, h2d_cmd.h2d.command, cmd);
    chk({tag, "_features"}, h2d_cmd.h2d.features, feat);
    chk({tag, "_lba"}, h2d_cmd.h2d.lba, lba);
    chk({tag, "_count"}, h2d_cmd.h2d.count, cnt);
    chk({tag, "_device"}, h2d_cmd.h2d.device, dev);
    chk({tag, "_control"}, h2d_cmd.h2d.control, ctrl);
  endtask

  task automatic ack_h2d(input string tag);
    @(negedge clk);
    h2d_ack = 1'b1;
    @(negedge clk);
    h2d_ack = 1'b0;
    chk({tag, "_req_cleared"}, h2d_req, 0);
    chk({tag, "_tready_back"}, s_tready, 1);
  endtask

  task automatic run_d2h(input string tag, input d2h_t c, input bit toggle,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic [31:0] w4);
    logic [31:0] ew [5];
    logic [7:0]  eu [5];
    int beats;
    int acks;
    ew = '{w0, w1, w2, w3, w4};
    eu = '{8'h3E, 8'h3C, 8'h3C, 8'h3C, 8'h3D};
    beats = 0;
    acks  = 0;
    @(negedge clk);
    d2h_cmd     = '0;
    d2h_cmd.d2h = c;
    d2h_req     = 1'b1;
    m_tready    = 1'b0;
    @(negedge clk);
    chk({tag, "_tvalid_latency"}, m_tvalid, 1);
    for (int cyc = 0; cyc < 60 && beats < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      m_tready = toggle ? cyc[0] : 1'b1;
      #1;
      if (d2h_ack) acks++;
      if (m_tvalid && m_tready) begin
        chk($sformatf("%s_dw%0d", tag, beats), m_tdata, ew[beats]);
        chk($sformatf("%s_tuser%0d", tag, beats), m_tuser, eu[beats]);
        if (beats == 4) begin
          chk({tag, "_ack_on_last"}, d2h_ack, 1);
          d2h_req = 1'b0;
        end
        beats++;
      end
    end
    chk({tag, "_beats"}, beats, 5);
    @(negedge clk);
    m_tready = 1'b1;
    chk({tag, "_tvalid_drop"}, m_tvalid, 0);
    chk({tag, "_ack_count"}, acks, 1);
    @(negedge clk);
    chk({tag, "_no_restart"}, m_tvalid, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tready"}, s_tready, 1);
    chk({tag, "_m_tvalid"}, m_tvalid, 0);
    chk({tag, "_m_tdata"}, m_tdata, 0);
    chk({tag, "_m_tuser"}, m_tuser, 0);
    chk({tag, "_h2d_req"}, h2d_req, 0);
    chk({tag, "_h2d_cmd"}, h2d_cmd.h2d.lba, 0);
    chk({tag, "_d2h_ack"}, d2h_ack, 0);
    chk({tag, "_rx_err"}, rx_err, 0);
  endtask

  initial begin
    d2h_t d;

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: good H2D
    send_h2d(32'h2780_2500, 32'h7856_3440, 32'h1200_0000, 32'h0800_0000);
    $display("txn h2d_basic: h2d_req=%0b cmd=%0h", h2d_req, h2d_cmd.h2d.command);
    chk_h2d("h2d_basic", 8'h25, 8'h00, 48'h0000_1234_5678, 16'h0008, 8'h40, 8'h00);
    repeat (3) @(negedge clk);
    chk("h2d_basic_stable_cmd", h2d_cmd.h2d.lba, 48'h0000_1234_5678);
    chk("h2d_basic_stable_req", h2d_req, 1);
    ack_h2d("h2d_basic");

    // 2: D2H with tready toggling
    d = '{status: 8'h50, error: 8'h00, lba: 48'h0000_1234_5678, count: 16'h0008, device: 8'h40};
    run_d2h("d2h_toggle", d, 1'b1,
            32'h3440_5000, 32'h7856_3440, 32'h1200_0000, 32'h0800_0000, 32'h0);
    $display("txn d2h_toggle: done");

    // 3: short frame, eop on beat 2
    send_beat(32'h2780_2500, 8'h3E);
    send_beat(32'h7856_3440, 8'h3C);
    send_beat(32'h1200_0000, 8'h3D);
    end_rx();
    $display("txn short: rx_err=%0b h2d_req=%0b", rx_err, h2d_req);
    chk("short_rx_err", rx_err, 1);
    chk("short_no_req", h2d_req, 0);
    @(negedge clk);
    chk("short_rx_err_pulse", rx_err, 0);
    send_h2d(32'h2780_3501, 32'h0F0E_0DE0, 32'h0C0B_0A00, 32'h2010_0008);
    $display("txn after_short: h2d_req=%0b", h2d_req);
    chk_h2d("after_short", 8'h35, 8'h01, 48'h0A0B_0C0D_0E0F, 16'h1020, 8'hE0, 8'h08);
    ack_h2d("after_short");

    // 4: long frame, 7 beats
    send_beat(32'h2780_2500, 8'h3E);
    for (int i = 1; i < 6; i++) send_beat(32'h1111_0000 + i, 8'h3C);
    send_beat(32'h0, 8'h3D);
    end_rx();
    $display("txn long: rx_err=%0b h2d_req=%0b", rx_err, h2d_req);
    chk("long_rx_err", rx_err, 1);
    chk("long_no_req", h2d_req, 0);
    chk("long_tready", s_tready, 1);

    // 5: wrong FIS type
    send_h2d(32'h4680_2500, 32'h7856_3440, 32'h1200_0000, 32'h0800_0000);
    $display("txn bad_type: rx_err=%0b h2d_req=%0b", rx_err, h2d_req);
`ifdef SATA_DEV_FIS_CHECK_EN
    chk("bad_type_rx_err", rx_err, 1);
    chk("bad_type_no_req", h2d_req, 0);
`else
    chk_h2d("bad_type_accept", 8'h25, 8'h00, 48'h0000_1234_5678, 16'h0008, 8'h40, 8'h00);
    ack_h2d("bad_type_accept");
`endif

    // 6: reset mid-TX (beat 2) and mid-RX
    @(negedge clk);
    d2h_cmd     = '0;
    d2h_cmd.d2h = d;
    d2h_req     = 1'b1;
    m_tready    = 1'b1;
    s_tvalid    = 1'b1;
    s_tdata     = 32'h2780_2500;
    s_tuser     = 8'h3E;
    @(negedge clk);
    s_tdata = 32'h7856_3440;
    s_tuser = 8'h3C;
    @(negedge clk);
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("midtx_beat2", m_tdata, 32'h1200_0000);
    rst_n    = 1'b0;
    d2h_req  = 1'b0;
    m_tready = 1'b0;
    #1;
    $display("txn reset_mid: m_tvalid=%0b s_tready=%0b", m_tvalid, s_tready);
    chk_reset_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    send_h2d(32'h2780_3501, 32'h0F0E_0DE0, 32'h0C0B_0A00, 32'h2010_0008);
    $display("txn post_reset_h2d: h2d_req=%0b", h2d_req);
    chk_h2d("post_reset_h2d", 8'h35, 8'h01, 48'h0A0B_0C0D_0E0F, 16'h1020, 8'hE0, 8'h08);
    ack_h2d("post_reset_h2d");
    d = '{status: 8'h41, error: 8'h04, lba: 48'hA1B2_C3D4_E5F6, count: 16'h0102, device: 8'hE0};
    run_d2h("post_reset_d2h", d, 1'b0,
            32'h3440_4104, 32'hF6E5_D4E0, 32'hC3B2_A100, 32'h0201_0000, 32'h0);
    $display("txn post_reset_d2h: done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
